lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//  Responder for the decoder's LCD request interface (strt/lcd_data/data_loc/loc_req -> lcd_done).
//  Powers up and initialises an HD44780-class character LCD over an 8-bit write-only bus.
//  Serves one decoder request per 4-phase handshake, with an optional cursor-address set before each character write.
//  Sits between the decoder and the LCD pins.
// PARAMETERS
//  PWRUP_WAIT_CYC  20000  idle cycles after reset release before the first init command
//  E_PULSE_CYC     8      cycles lcd_en is held high per bus write
//  CMD_WAIT_CYC    2000   cycles after lcd_en falls, for ordinary commands and data
//  CLR_WAIT_CYC    80000  cycles after lcd_en falls, for clear-display (0x01)
// PORTS
//  clk        in   1  system clock
//  sys_rst_n  in   1  asynchronous active-low reset
//  strt       in   1  request from decoder; level, held high until lcd_done seen
//  lcd_data   in   8  character code to write
//  data_loc   in   8  DDRAM address; bit 7 ignored
//  loc_req    in   1  1: set address to data_loc before writing the character
//  lcd_done   out  1  request complete; held high until strt low
//  ready      out  1  init finished and FSM in IDLE
//  lcd_rs     out  1  LCD register select (0 cmd, 1 data)
//  lcd_rw     out  1  LCD read/write; tied 0 (write-only)
//  lcd_en     out  1  LCD enable strobe
//  lcd_db     out  8  LCD data bus
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): all outputs 0 immediately, FSM->PWRUP, all counters 0. Asserting reset mid-write aborts the write (lcd_en drops at once); init reruns on release.
//  Bus write (one transaction):
//   - cycle 0: setup; rs/db driven, en=0.
//   - E_PULSE_CYC cycles with en=1.
//   - en=0 for the wait count (CLR_WAIT_CYC if byte is 0x01 with rs=0, else CMD_WAIT_CYC).
//   - rs/db stay stable through the whole transaction.
//   - Total length L = 1 + E_PULSE_CYC + wait.
//  FSM states: PWRUP -> INIT0(0x38) -> INIT1(0x0C) -> INIT2(0x01) -> INIT3(0x06) -> IDLE -> [SETADDR] -> WRCHAR -> DONE -> IDLE.
//   - PWRUP counts PWRUP_WAIT_CYC cycles, then moves on.
//   - Each INITn performs one command write (rs=0).
//   - IDLE: ready=1. On strt=1, latch lcd_data, data_loc and loc_req, drop ready, and go to SETADDR if loc_req=1, else WRCHAR.
//   - SETADDR writes cmd 0x80|data_loc[6:0] (rs=0).
//   - WRCHAR writes the latched lcd_data (rs=1).
//   - DONE: lcd_done=1; hold until strt=0, then lcd_done=0 and go to IDLE in the same cycle.
//  Latency: strt sampled high in IDLE at edge N.
//   - lcd_en rises at edge N+2.
//   - lcd_done rises at N+1+L, or N+1+2L when loc_req=1.
//  strt during PWRUP/INIT is not accepted; it is served once IDLE is reached if still high. Input changes after latching do not affect an in-flight request.
//  strt still high when DONE exits is impossible by construction: no re-trigger without strt falling.
//  Counters are $clog2(max(PWRUP_WAIT_CYC, CLR_WAIT_CYC)+1) bits wide, with no wrap: each counter saturates at its terminal count and reloads per transaction.
//  lcd_rw=0 always; lcd_db=0 and lcd_rs=0 whenever no transaction is active.
// STRUCTURE
//  lcd_defs.vh: command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, SET_DDRAM 0x80) and state encodings.
//  Sub-module lcd_bus_write:
//   - inputs go, rs, byte, long_wait; outputs en, rs/db, wdone (1-cycle pulse).
//   - owns the E-pulse and wait counters.
//  The lcd_ctrl FSM sequences lcd_bus_write.
// TESTING (params PWRUP=20, E=2, CMD=5, CLR=10 -> L=8, clear L=13)
//  1. Release reset.
//     -> db sequence 0x38, 0x0C, 0x01, 0x06 with rs=0, each with a 2-cycle en pulse.
//     -> ready rises 57 cycles after release.
//  2. IDLE, strt=1, loc_req=0, lcd_data=0x41.
//     -> one en pulse with rs=1, db=0x41.
//     -> lcd_done at N+9, held until strt=0, then ready=1.
//  3. strt=1, loc_req=1, data_loc=0x45, lcd_data=0x42.
//     -> db=0xC5 (rs=0), then db=0x42 (rs=1); lcd_done at N+17.
//  4. strt=1 held from reset release.
//     -> no en pulse except init commands; request served right after ready.
//  5. sys_rst_n low during en=1 of WRCHAR.
//     -> en, rs, db and lcd_done drop the same instant; on release, init restarts from PWRUP.
//  6. strt held 50 cycles after lcd_done.
//     -> exactly one data write; lcd_done stays 1 and ready stays 0 until strt falls.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the HD44780 LCD controller: command bytes, FSM encodings, counter sizing.
// No logic; imported by lcd_ctrl and lcd_bus_write.
package lcd_ctrl_pkg;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT0,
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_IDLE,
        ST_SETADDR,
        ST_WRCHAR,
        ST_DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_SETUP,
        BW_PULSE,
        BW_WAIT
    } bw_state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// One LCD bus write: 1 setup cycle, E_PULSE_CYC cycles of en, then the settle wait; wdone pulses on the last wait cycle.
// A go presented with wdone starts the next write back-to-back; go while busy otherwise is ignored.
module lcd_bus_write
    import lcd_ctrl_pkg::*;
#(
    parameter int E_PULSE_CYC  = 8,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 80000,
    parameter int CW           = 17
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       go_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    input  logic       long_wait_i,
    output logic       en_o,
    output logic       rs_o,
    output logic [7:0] db_o,
    output logic       wdone_o
);

    localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);

    bw_state_e     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          long_q, long_d;
    logic [CW-1:0] wait_last;
    logic          wdone;

    assign wait_last = long_q ? CLR_LAST : CMD_LAST;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rs_d   = rs_q;
        db_d   = db_q;
        long_d = long_q;
        wdone  = 1'b0;
        case (st_q)
            BW_IDLE: ;
            BW_SETUP: begin
                st_d  = BW_PULSE;
                cnt_d = '0;
            end
            BW_PULSE: begin
                if (cnt_q == E_LAST) begin
                    st_d  = BW_WAIT;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BW_WAIT: begin
                if (cnt_q == wait_last) begin
                    wdone = 1'b1;
                    st_d  = BW_IDLE;
                    rs_d  = 1'b0;
                    db_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = BW_IDLE;
        endcase
        // Chained start: the next write's setup cycle directly follows the last wait cycle.
        if (go_i && (st_q == BW_IDLE || wdone)) begin
            st_d   = BW_SETUP;
            cnt_d  = '0;
            rs_d   = rs_i;
            db_d   = byte_i;
            long_d = long_wait_i;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q   <= BW_IDLE;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            db_q   <= 8'h00;
            long_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            en_q   <= (st_d == BW_PULSE);
            rs_q   <= rs_d;
            db_q   <= db_d;
            long_q <= long_d;
        end
    end

    assign en_o    = en_q;
    assign rs_o    = rs_q;
    assign db_o    = db_q;
    assign wdone_o = wdone;

endmodule

// File: rtl/lcd_ctrl.sv
// LCD power-up/init sequencer and decoder request responder; lcd_en rises 2 cycles after strt is taken, done after 1+L (1+2L with address set).
// Decoder handshake is 4-phase: strt held until lcd_done, lcd_done held until strt drops; strt ignored until init completes.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int PWRUP_WAIT_CYC = 20000,
    parameter int E_PULSE_CYC    = 8,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLR_WAIT_CYC   = 80000
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       strt,
    input  logic [7:0] lcd_data,
    input  logic [7:0] data_loc,
    input  logic       loc_req,
    output logic       lcd_done,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_db
);

    localparam int            CW       = cnt_width(PWRUP_WAIT_CYC, CLR_WAIT_CYC);
    localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_WAIT_CYC - 1);

    ctrl_state_e   st_q, st_d;
    logic [CW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [6:0]    loc_q, loc_d;
    logic          issue_q, issue_d;
    logic          done_q, ready_q;

    logic          bw_go, bw_rs, bw_long, bw_wdone;
    logic [7:0]    bw_byte;
    logic          unused_loc_msb;

    assign unused_loc_msb = data_loc[7];

    always_comb begin
        st_d      = st_q;
        pwr_cnt_d = pwr_cnt_q;
        data_d    = data_q;
        loc_d     = loc_q;
        issue_d   = 1'b0;
        bw_go     = 1'b0;
        bw_rs     = 1'b0;
        bw_byte   = 8'h00;
        case (st_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    st_d    = ST_INIT0;
                    bw_go   = 1'b1;
                    bw_byte = CMD_FUNC_SET;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT0: begin
                if (bw_wdone) begin
                    st_d    = ST_INIT1;
                    bw_go   = 1'b1;
                    bw_byte = CMD_DISP_ON;
                end
            end
            ST_INIT1: begin
                if (bw_wdone) begin
                    st_d    = ST_INIT2;
                    bw_go   = 1'b1;
                    bw_byte = CMD_CLEAR;
                end
            end
            ST_INIT2: begin
                if (bw_wdone) begin
                    st_d    = ST_INIT3;
                    bw_go   = 1'b1;
                    bw_byte = CMD_ENTRY;
                end
            end
            ST_INIT3: begin
                if (bw_wdone) st_d = ST_IDLE;
            end
            ST_IDLE: begin
                // The request is snapshotted here so later input changes cannot disturb it.
                if (strt) begin
                    data_d  = lcd_data;
                    loc_d   = data_loc[6:0];
                    issue_d = 1'b1;
                    st_d    = loc_req ? ST_SETADDR : ST_WRCHAR;
                end
            end
            ST_SETADDR: begin
                if (issue_q) begin
                    bw_go   = 1'b1;
                    bw_byte = CMD_SET_DDRAM | {1'b0, loc_q};
                end
                if (bw_wdone) begin
                    st_d    = ST_WRCHAR;
                    bw_go   = 1'b1;
                    bw_rs   = 1'b1;
                    bw_byte = data_q;
                end
            end
            ST_WRCHAR: begin
                if (issue_q) begin
                    bw_go   = 1'b1;
                    bw_rs   = 1'b1;
                    bw_byte = data_q;
                end
                if (bw_wdone) st_d = ST_DONE;
            end
            ST_DONE: begin
                if (!strt) st_d = ST_IDLE;
            end
            default: st_d = ST_PWRUP;
        endcase
        bw_long = !bw_rs && (bw_byte == CMD_CLEAR);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q      <= ST_PWRUP;
            pwr_cnt_q <= '0;
            data_q    <= 8'h00;
            loc_q     <= 7'h00;
            issue_q   <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            pwr_cnt_q <= pwr_cnt_d;
            data_q    <= data_d;
            loc_q     <= loc_d;
            issue_q   <= issue_d;
            done_q    <= (st_d == ST_DONE);
            ready_q   <= (st_d == ST_IDLE);
        end
    end

    lcd_bus_write #(
        .E_PULSE_CYC (E_PULSE_CYC),
        .CMD_WAIT_CYC(CMD_WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC),
        .CW          (CW)
    ) u_bus_write (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .go_i       (bw_go),
        .rs_i       (bw_rs),
        .byte_i     (bw_byte),
        .long_wait_i(bw_long),
        .en_o       (lcd_en),
        .rs_o       (lcd_rs),
        .db_o       (lcd_db),
        .wdone_o    (bw_wdone)
    );

    assign lcd_done = done_q;
    assign ready    = ready_q;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters (L=8, clear L=13).
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst_n, strt, loc_req;
    logic [7:0] lcd_data, data_loc;
    logic       lcd_done, ready, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_db;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .PWRUP_WAIT_CYC(20),
        .E_PULSE_CYC   (2),
        .CMD_WAIT_CYC  (5),
        .CLR_WAIT_CYC  (10)
    ) dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .strt     (strt),
        .lcd_data (lcd_data),
        .data_loc (data_loc),
        .loc_req  (loc_req),
        .lcd_done (lcd_done),
        .ready    (ready),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_db   (lcd_db)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: records every en pulse as {rs,db} plus its rise cycle.
    logic [8:0] wr_q[$];
    int         rise_q[$];
    logic [8:0] cur;
    logic       en_prev = 1'b0;
    int         w = 0;
    int         stab_bad = 0;
    int         rw_bad = 0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (!sys_rst_n) begin
            en_prev = 1'b0;
            w = 0;
        end else begin
            if (lcd_en) begin
                if (!en_prev) begin
                    cur = {lcd_rs, lcd_db};
                    wr_q.push_back(cur);
                    rise_q.push_back(cyc);
                    w = 1;
                end else begin
                    w++;
                    if ({lcd_rs, lcd_db} !== cur) stab_bad++;
                end
            end else if (en_prev) begin
                chk("en_width", w, 2);
            end
            en_prev = lcd_en;
        end
    end

    typedef struct {
        logic       lreq;
        logic [7:0] dat;
        logic [7:0] loc;
        int         nwr;
        logic [8:0] w0;
        logic [8:0] w1;
        int         lat;
        int         hold;
    } vec_t;

    vec_t       vecs[5];
    logic [8:0] init_wr[4];
    int         init_rise[4];

    task automatic check_init(input int r, input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ready) break;
        end
        chk({tag, "_ready_at"}, cyc - r, 57);
        chk({tag, "_init_cnt"}, (wr_q.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_q.size()) begin
                chk($sformatf("%s_init%0d_wr", tag, i), wr_q[i], init_wr[i]);
                chk($sformatf("%s_init%0d_rise", tag, i), rise_q[i] - r, init_rise[i]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, k, bad;
        wr_q.delete();
        rise_q.delete();
        @(posedge clk); #1;
        loc_req  = v.lreq;
        lcd_data = v.dat;
        data_loc = v.loc;
        strt     = 1'b1;
        n        = cyc + 1;
        @(posedge clk); #1;
        loc_req  = ~v.lreq;
        lcd_data = ~v.dat;
        data_loc = v.loc ^ 8'h7F;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (lcd_done) break;
        end
        chk($sformatf("v%0d_done_lat", idx), cyc - n, v.lat);
        chk($sformatf("v%0d_ready_busy", idx), ready, 0);
        chk($sformatf("v%0d_bus_idle", idx), {lcd_rs, lcd_db}, 0);
        chk($sformatf("v%0d_nwr", idx), wr_q.size(), v.nwr);
        if (wr_q.size() > 0) begin
            chk($sformatf("v%0d_wr0", idx), wr_q[0], v.w0);
            chk($sformatf("v%0d_rise0", idx), rise_q[0] - n, 2);
        end
        if (v.nwr == 2 && wr_q.size() > 1) begin
            chk($sformatf("v%0d_wr1", idx), wr_q[1], v.w1);
            chk($sformatf("v%0d_rise1", idx), rise_q[1] - n, 10);
        end
        bad = 0;
        repeat (v.hold) begin
            @(negedge clk);
            if (lcd_done !== 1'b1 || ready !== 1'b0) bad++;
        end
        chk($sformatf("v%0d_hold", idx), bad, 0);
        chk($sformatf("v%0d_nwr_after_hold", idx), wr_q.size(), v.nwr);
        @(posedge clk); #1;
        strt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_done_clr", idx), lcd_done, 0);
        chk($sformatf("v%0d_ready_back", idx), ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r, k;

        init_wr   = '{9'h038, 9'h00C, 9'h001, 9'h006};
        init_rise = '{21, 29, 37, 50};
        vecs[0] = '{1'b0, 8'h41, 8'h00, 1, {1'b1, 8'h41}, 9'h000, 9, 0};
        vecs[1] = '{1'b1, 8'h42, 8'h45, 2, {1'b0, 8'hC5}, {1'b1, 8'h42}, 17, 0};
        vecs[2] = '{1'b0, 8'h01, 8'h00, 1, {1'b1, 8'h01}, 9'h000, 9, 50};
        vecs[3] = '{1'b1, 8'h7E, 8'hFF, 2, {1'b0, 8'hFF}, {1'b1, 8'h7E}, 17, 3};
        vecs[4] = '{1'b1, 8'h00, 8'h80, 2, {1'b0, 8'h80}, {1'b1, 8'h00}, 17, 0};

        sys_rst_n = 1'b1;
        strt      = 1'b0;
        loc_req   = 1'b0;
        lcd_data  = 8'h00;
        data_loc  = 8'h00;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_done", lcd_done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_rw", lcd_rw, 0);

        // Power-up and init sequence.
        repeat (3) @(posedge clk);
        #1 sys_rst_n = 1'b1;
        r = cyc;
        check_init(r, "pwrup");
        chk("pwrup_init_exact", wr_q.size(), 4);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // strt held high from reset release: served right after ready.
        sys_rst_n = 1'b0;
        wr_q.delete();
        rise_q.delete();
        strt     = 1'b1;
        loc_req  = 1'b0;
        lcd_data = 8'h55;
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        r = cyc;
        check_init(r, "early");
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (lcd_done) break;
        end
        chk("early_done_at", cyc - r, 67);
        chk("early_nwr", wr_q.size(), 5);
        if (wr_q.size() > 4) begin
            chk("early_wr4", wr_q[4], {1'b1, 8'h55});
            chk("early_rise4", rise_q[4] - r, 60);
        end
        @(posedge clk); #1;
        strt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("early_ready_back", ready, 1);

        // Reset while the character write's en pulse is high.
        @(posedge clk); #1;
        lcd_data = 8'h41;
        loc_req  = 1'b0;
        strt     = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (lcd_en) break;
        end
        chk("abort_en_seen", lcd_en, 1);
        chk("abort_bus_before", {lcd_rs, lcd_db}, {1'b1, 8'h41});
        sys_rst_n = 1'b0;
        #1;
        chk("abort_en", lcd_en, 0);
        chk("abort_rs", lcd_rs, 0);
        chk("abort_db", lcd_db, 0);
        chk("abort_done", lcd_done, 0);
        chk("abort_ready", ready, 0);
        strt = 1'b0;
        repeat (3) @(negedge clk);
        wr_q.delete();
        rise_q.delete();
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        r = cyc;
        check_init(r, "rerun");
        chk("rerun_init_exact", wr_q.size(), 4);

        chk("bus_stable_in_pulse", stab_bad, 0);
        chk("rw_low", rw_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
